// File: rtl/i2c_mux_stretch_ctrl_if.sv
// i2c_mux_stretch_ctrl_if: SCL, channel-select and status signals of the I2C mux.
// Ports (signals):
//   i2c_scl          upstream SCL
//   smclk            downstream SCL readback per channel
//   sclk_oen         downstream SCL drive per channel, 0 = pull low
//   sw_en            requested channel enables (multi-hot)
//   switch_direction 0 = upstream to slaves, 1 = slaves to upstream
//   en_active        enables currently in effect
//   state            1 = SCL-high phase
//   bus_busy         1 between START and STOP
//   stretch_err      sticky stretch-timeout flag
// master: the side driving the bus and the enables; slave: the mux.
interface i2c_mux_stretch_ctrl_if #(parameter int N_CH = 12);
    logic            i2c_scl;
    logic [N_CH-1:0] smclk;
    logic [N_CH-1:0] sclk_oen;
    logic [N_CH-1:0] sw_en;
    logic            switch_direction;
    logic [N_CH-1:0] en_active;
    logic            state;
    logic            bus_busy;
    logic            stretch_err;
    modport master (
        output i2c_scl, smclk, sw_en, switch_direction,
        input  sclk_oen, en_active, state, bus_busy, stretch_err
    );
    modport slave (
        input  i2c_scl, smclk, sw_en, switch_direction,
        output sclk_oen, en_active, state, bus_busy, stretch_err
    );
endinterface

// File: rtl/i2c_mux_stretch_ctrl.sv
// i2c_mux_stretch_ctrl: I2C channel mux that regenerates the downstream SCL low phase and waits out slave clock stretching.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   i2c_sda    upstream SDA, open-drain
//   sda_slave  downstream SDA per channel, open-drain
//   bus        i2c_mux_stretch_ctrl_if.slave (SCL, enables, direction, status)
module i2c_mux_stretch_ctrl #(
    parameter int N_CH       = 12,
    parameter int CNT_W      = 10,
    parameter int LOW_DLY    = 141,
    parameter int STRETCH_TO = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire                   i2c_sda,
    inout  wire  [N_CH-1:0]       sda_slave,
    i2c_mux_stretch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_HIGH, S_LOW, S_STRETCH} fsm_t;
    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(LOW_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(STRETCH_TO - 1);
    fsm_t            fsm, fsm_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]      scl_sy, sda_sy;
    logic            scl_p, sda_p;
    logic [N_CH-1:0] mk_m, mk_s, en;
    logic            busy, err, neg, start, stop, released, timeout;
    // SCL/SDA synchronizers idle high so reset never fakes an edge; scl_p/sda_p hold the previous synchronized value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sy <= 2'b11;
            sda_sy <= 2'b11;
            scl_p  <= 1'b1;
            sda_p  <= 1'b1;
            mk_m   <= '0;
            mk_s   <= '0;
        end else begin
            scl_sy <= {scl_sy[0], bus.i2c_scl};
            sda_sy <= {sda_sy[0], i2c_sda};
            scl_p  <= scl_sy[1];
            sda_p  <= sda_sy[1];
            mk_m   <= bus.smclk;
            mk_s   <= mk_m;
        end
    end
    assign neg      = scl_p & ~scl_sy[1];
    assign start    = scl_sy[1] & sda_p & ~sda_sy[1];
    assign stop     = scl_sy[1] & ~sda_p & sda_sy[1];
    assign released = &(mk_s | ~en);
    // A timeout in the same cycle as START leaves the error flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            err  <= 1'b0;
            en   <= '0;
            fsm  <= S_HIGH;
            cnt  <= '0;
        end else begin
            busy <= start | (busy & ~stop);
            err  <= timeout | (err & ~start);
            en   <= busy ? en : bus.sw_en;
            fsm  <= fsm_nxt;
            cnt  <= cnt_nxt;
        end
    end
    always_comb begin
        fsm_nxt = fsm;
        cnt_nxt = cnt + CNT_W'(1);
        timeout = 1'b0;
        case (fsm)
            S_HIGH: begin
                cnt_nxt = '0;
                fsm_nxt = neg ? S_LOW : S_HIGH;
            end
            S_LOW: begin
                if (cnt == LOW_LAST) begin
                    fsm_nxt = S_STRETCH;
                    cnt_nxt = '0;
                end
            end
            S_STRETCH: begin
                if (released || cnt == TO_LAST) begin
                    fsm_nxt = S_HIGH;
                    cnt_nxt = '0;
                    timeout = !released;
                end
            end
            default: begin
                fsm_nxt = S_HIGH;
                cnt_nxt = '0;
            end
        endcase
    end
    assign bus.state       = (fsm == S_HIGH);
    assign bus.sclk_oen    = ~en | {N_CH{fsm != S_LOW}};
    assign bus.en_active   = en;
    assign bus.bus_busy    = busy;
    assign bus.stretch_err = err;
    // Direction gates which side drives, so only one of the two open-drain paths is ever active.
    for (genvar i = 0; i < N_CH; i++) begin : g_sda
        assign sda_slave[i] = (en[i] && !bus.switch_direction && !i2c_sda) ? 1'b0 : 1'bz;
    end
    assign i2c_sda = (bus.switch_direction && |(en & ~sda_slave)) ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_mux_stretch_ctrl.sv
// tb_i2c_mux_stretch_ctrl: self-checking bench for i2c_mux_stretch_ctrl with a cycle-level reference model.
module tb_i2c_mux_stretch_ctrl;
    localparam int N   = 12;
    localparam int LOW = 141;
    localparam int STO = 1000;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic         m_scl = 1'b1, m_sda = 1'b1, dir = 1'b0, hold = 1'b0;
    logic [N-1:0] s_drv = '1, sw = '0;
    tri1          i2c_sda;
    tri1 [N-1:0]  sda_slave;
    int           n_chk = 0, n_fail = 0;
    i2c_mux_stretch_ctrl_if #(.N_CH(N)) bus ();
    assign i2c_sda              = m_sda ? 1'bz : 1'b0;
    for (genvar g = 0; g < N; g++) begin : g_slv
        assign sda_slave[g] = s_drv[g] ? 1'bz : 1'b0;
    end
    assign bus.i2c_scl          = m_scl;
    assign bus.sw_en            = sw;
    assign bus.switch_direction = dir;
    assign bus.smclk            = bus.sclk_oen & ~{N{hold}};
    i2c_mux_stretch_ctrl #(.N_CH(N), .CNT_W(10), .LOW_DLY(LOW), .STRETCH_TO(STO)) dut (
        .clk(clk), .rst(rst), .i2c_sda(i2c_sda), .sda_slave(sda_slave), .bus(bus.slave)
    );
    // Reference model: a synchronized line is the raw sample taken two edges earlier.
    logic [2:0]   h_scl, h_sda;
    logic [N-1:0] h_mk0, h_mk1, m_en, e_oen, e_slave, e_smclk;
    logic         m_busy, m_err, e_sda, m_neg, m_start, m_stop, m_rel, m_to;
    int           m_phase, m_left, m_age;
    assign e_oen   = ~m_en | {N{m_phase != 1}};
    assign e_sda   = m_sda & ~(dir & |(m_en & ~s_drv));
    assign e_slave = s_drv & ~(m_en & {N{~dir & ~e_sda}});
    assign e_smclk = e_oen & ~{N{hold}};
    assign m_neg   = h_scl[2] & ~h_scl[1];
    assign m_start = h_scl[1] & h_sda[2] & ~h_sda[1];
    assign m_stop  = h_scl[1] & ~h_sda[2] & h_sda[1];
    assign m_rel   = &(h_mk1 | ~m_en);
    assign m_to    = (m_phase == 2) && !m_rel && (m_age == STO - 1);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_scl   <= 3'b111;
            h_sda   <= 3'b111;
            h_mk0   <= '0;
            h_mk1   <= '0;
            m_en    <= '0;
            m_busy  <= 1'b0;
            m_err   <= 1'b0;
            m_phase <= 0;
            m_left  <= 0;
            m_age   <= 0;
        end else begin
            h_scl  <= {h_scl[1:0], m_scl};
            h_sda  <= {h_sda[1:0], e_sda};
            h_mk0  <= e_smclk;
            h_mk1  <= h_mk0;
            if (!m_busy) m_en <= sw;
            if (m_start) m_busy <= 1'b1;
            else if (m_stop) m_busy <= 1'b0;
            if (m_to) m_err <= 1'b1;
            else if (m_start) m_err <= 1'b0;
            if (m_phase == 0 && m_neg) begin
                m_phase <= 1;
                m_left  <= LOW;
            end else if (m_phase == 1) begin
                m_left <= m_left - 1;
                m_age  <= 0;
                if (m_left == 1) m_phase <= 2;
            end else if (m_phase == 2) begin
                if (m_rel || m_to) m_phase <= 0;
                else m_age <= m_age + 1;
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("sclk_oen", 32'(bus.sclk_oen), 32'(e_oen));
        chk("state", 32'(bus.state), 32'(m_phase == 0));
        chk("en_active", 32'(bus.en_active), 32'(m_en));
        chk("bus_busy", 32'(bus.bus_busy), 32'(m_busy));
        chk("stretch_err", 32'(bus.stretch_err), 32'(m_err));
        chk("i2c_sda", 32'(i2c_sda), 32'(e_sda));
        chk("sda_slave", 32'(sda_slave), 32'(e_slave));
    end
    // Measured lengths of the last channel-0 low phase and stretch phase.
    int cur_low = 0, last_low = 0, cur_st = 0, last_st = 0;
    always @(negedge clk) begin
        if (bus.en_active[0] && !bus.sclk_oen[0]) cur_low <= cur_low + 1;
        else if (cur_low != 0) begin
            last_low <= cur_low;
            cur_low  <= 0;
        end
        if (bus.en_active[0] && bus.sclk_oen[0] && !bus.state) cur_st <= cur_st + 1;
        else if (cur_st != 0) begin
            last_st <= cur_st;
            cur_st  <= 0;
        end
    end
    logic [N-1:0] lat2, lat3;
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_high();
        int k = 0;
        while (bus.state !== 1'b1 && k < 2500) begin
            tick(1);
            k++;
        end
        chk("phase_done", 32'(bus.state), 32'd1);
    endtask
    // One SCL low pulse; v is the SDA level set during the low phase, rel >= 0 releases the stretch hold rel cycles after SCL release.
    task automatic scl_bit(input logic v, input int rel);
        m_scl = 1'b0;
        tick(2);
        lat2 = bus.sclk_oen;
        tick(1);
        lat3 = bus.sclk_oen;
        m_sda = v;
        if (rel >= 0) begin
            for (int i = 0; i < 400 && bus.sclk_oen[0] !== 1'b1; i++) tick(1);
            tick(rel);
            hold = 1'b0;
        end
        wait_high();
        m_scl = 1'b1;
        tick(5);
    endtask
    initial begin
        tick(3);
        chk("rst_state", 32'(bus.state), 32'd1);
        chk("rst_oen", 32'(bus.sclk_oen), 32'hfff);
        chk("rst_en", 32'(bus.en_active), 32'h0);
        chk("rst_err", 32'(bus.stretch_err), 32'd0);
        chk("rst_i2c_sda", 32'(i2c_sda), 32'd1);
        rst = 1'b1;
        sw  = 12'h001;
        tick(3);
        chk("idle_load", 32'(bus.en_active), 32'h001);
        m_sda = 1'b0;
        tick(5);
        chk("start_busy", 32'(bus.bus_busy), 32'd1);
        chk("route_down", 32'(sda_slave), 32'hffe);
        scl_bit(1'b0, -1);
        chk("lat_edge2", 32'(lat2), 32'hfff);
        chk("lat_edge3", 32'(lat3), 32'hffe);
        tick(2);
        chk("low_len", 32'(last_low), 32'd141);
        chk("stretch_fast", 32'(last_st), 32'd3);
        hold = 1'b1;
        scl_bit(1'b0, 49);
        tick(2);
        chk("stretch_rel", 32'(last_st), 32'd52);
        chk("rel_err", 32'(bus.stretch_err), 32'd0);
        sw = 12'h800;
        tick(3);
        chk("freeze", 32'(bus.en_active), 32'h001);
        scl_bit(1'b0, -1);
        m_sda = 1'b1;
        tick(5);
        chk("stop_idle", 32'(bus.bus_busy), 32'd0);
        chk("unfreeze", 32'(bus.en_active), 32'h800);
        sw = 12'h001;
        tick(3);
        m_sda = 1'b0;
        tick(5);
        hold = 1'b1;
        scl_bit(1'b0, -1);
        tick(2);
        chk("timeout_len", 32'(last_st), 32'd1000);
        chk("timeout_err", 32'(bus.stretch_err), 32'd1);
        hold = 1'b0;
        scl_bit(1'b1, -1);
        chk("err_sticky", 32'(bus.stretch_err), 32'd1);
        m_sda = 1'b0;
        tick(5);
        chk("err_clear", 32'(bus.stretch_err), 32'd0);
        scl_bit(1'b0, -1);
        m_sda = 1'b1;
        tick(5);
        sw = 12'h002;
        tick(3);
        chk("en_ch1", 32'(bus.en_active), 32'h002);
        dir      = 1'b1;
        s_drv[5] = 1'b0;
        tick(1);
        chk("route_up_masked", 32'(i2c_sda), 32'd1);
        s_drv    = '1;
        s_drv[1] = 1'b0;
        tick(1);
        chk("route_up", 32'(i2c_sda), 32'd0);
        s_drv = '1;
        tick(5);
        dir = 1'b0;
        sw  = 12'h001;
        tick(5);
        m_sda = 1'b0;
        tick(5);
        m_scl = 1'b0;
        tick(10);
        chk("mid_low_state", 32'(bus.state), 32'd0);
        chk("mid_low_oen", 32'(bus.sclk_oen), 32'hffe);
        #2 rst = 1'b0;
        #1;
        chk("arst_oen", 32'(bus.sclk_oen), 32'hfff);
        chk("arst_state", 32'(bus.state), 32'd1);
        chk("arst_en", 32'(bus.en_active), 32'h0);
        chk("arst_busy", 32'(bus.bus_busy), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(5);
        wait_high();
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_mux_stretch_ctrl.md
I2C_MUX_STRETCH_CTRL -- requirements
Module: i2c_mux_stretch_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 12: number of downstream I2C channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 10: width of the internal low-phase and stretch counters.
REQ-003 SHALL have parameter LOW_DLY, default 141: clk cycles the enabled downstream SCLs are held low per bit (1..2^CNT_W-1).
REQ-004 SHALL have parameter STRETCH_TO, default 1000: maximum clk cycles to wait for slave clock-stretch release (1..2^CNT_W-1).
REQ-005 SHALL have ports, in order:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- i2c_scl  input  1  upstream SCL.
- i2c_sda  inout  1  upstream SDA; open-drain.
- sda_slave  inout  N_CH  downstream SDA per channel; open-drain.
- smclk  input  N_CH  downstream SCL readback per channel.
- sclk_oen  output  N_CH  downstream SCL drive per channel; 0 = pull low.
- sw_en  input  N_CH  requested channel enables; one bit per channel; multi-hot allowed.
- switch_direction  input  1  0 = upstream to slaves, 1 = slaves to upstream.
- en_active  output  N_CH  enables currently in effect.
- state  output  1  1 = SCL-high phase, 0 = low or stretch phase.
- bus_busy  output  1  1 between START and STOP.
- stretch_err  output  1  sticky stretch-timeout flag.

Function
REQ-006 SHALL pass i2c_scl, i2c_sda and each smclk bit through a 2-flop synchronizer before any use in sequential logic.
REQ-007 SHALL assert internal neg for one cycle when synchronized SCL is 0 and its previous synchronized value is 1.
REQ-008 SHALL detect START and STOP on synchronized lines while synchronized SCL is 1:
- START = SDA 1->0; sets bus_busy.
- STOP = SDA 0->1; clears bus_busy.
REQ-009 SHALL load en_active from sw_en on every cycle in which bus_busy is 0, including the cycle START is detected, and SHALL hold en_active while bus_busy is 1.
REQ-010 SHALL drive sda_slave[i] to 0 when en_active[i]=1, switch_direction=0 and i2c_sda=0, and SHALL leave it high-Z otherwise.
REQ-011 SHALL drive i2c_sda to 0 when switch_direction=1 and any channel i with en_active[i]=1 has sda_slave[i]=0, and SHALL leave it high-Z otherwise; channels with en_active[i]=0 SHALL NOT affect i2c_sda.
REQ-012 SHALL drive sclk_oen[i] = sclk_ctrl when en_active[i]=1, and 1 when en_active[i]=0.
REQ-013 SHALL implement the FSM as follows:
- S_HIGH: sclk_ctrl=1, state=1. On neg -> S_LOW, sclk_ctrl<=0, counter<=0.
- S_LOW: state=0; counter increments each cycle. When counter = LOW_DLY-1 -> S_STRETCH, sclk_ctrl<=1, counter<=0.
- S_STRETCH: state=0. If every enabled synchronized smclk bit is 1 (vacuously true when en_active=0) -> S_HIGH. Otherwise counter increments. When counter = STRETCH_TO-1 -> S_HIGH and stretch_err<=1.
REQ-014 SHALL give the following latencies:
- sclk_oen of enabled channels goes 0 at the 3rd rising clk edge after i2c_scl is first sampled low.
- sclk_oen stays 0 for exactly LOW_DLY cycles.
REQ-015 SHALL ignore neg in S_LOW and S_STRETCH; no queuing.
REQ-016 SHALL clear stretch_err on START detection; if the timeout and START occur in the same cycle, set SHALL win.
REQ-017 SHALL NOT wrap counters; they are cleared on every state entry.

Reset
REQ-018 SHALL, while rst=0, asynchronously force:
- FSM=S_HIGH, state=1, sclk_ctrl=1, sclk_oen all 1.
- en_active=0, bus_busy=0, stretch_err=0.
- counters and synchronizers=0 (SCL/SDA synchronizers to 1).
- all sda_slave and i2c_sda high-Z.
REQ-019 SHALL apply REQ-018 mid-transaction with no further bus activity; after rst rises, the next neg is the first acted upon.

Verification
REQ-020 SHALL cover basic bit: N_CH=12, sw_en=12'h001, START, i2c_scl fall -> sclk_oen[0]=0 from edge 3 for 141 cycles, sclk_oen[11:1]=all 1, state 1->0->1.
REQ-021 SHALL cover stretch release: smclk[0] held 0 for 50 cycles after release -> S_STRETCH for 50+2 cycles, stretch_err=0.
REQ-022 SHALL cover stretch timeout: smclk[0] stuck 0 -> return to S_HIGH after 1000 cycles, stretch_err=1; next START -> stretch_err=0.
REQ-023 SHALL cover enable freeze: sw_en changed 12'h001->12'h800 while bus_busy=1 -> en_active stays 12'h001 until STOP, then 12'h800.
REQ-024 SHALL cover SDA routing: switch_direction=1, en_active=12'h002, sda_slave[5]=0 -> i2c_sda high-Z; sda_slave[1]=0 -> i2c_sda=0.
REQ-025 SHALL cover reset in S_LOW: rst=0 mid-phase -> sclk_oen all 1 and state=1 immediately, en_active=0.
